quantum_scheduler: RTL
======================

Name: quantum_scheduler

Overview:
- Preemption timer and context-switch sequencer for multiprogrammed execution.
- Holds the values written by SET_QUANTUM, SET_MULTIPROG and SET_ADDR_CS, and counts instruction cycles of the running user program.
- On quantum expiry it raises flagCS for one cycle, presents the OS context-switch routine address to the PC path, and saves the preempted PC for GET_PC_PROCESS.
- Sits beside the control unit: consumes its flagSetValue/flagExecProc/flagHALT outputs and drives its flagCS input.

Parameters:
- AW, 10, instruction-memory address width (PC width).
- DW, 32, register-file data width (source of set values).
- QW, 16, quantum counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flagSetValue  in  2  0 none, 1 SET_QUANTUM, 2 SET_MULTIPROG, 3 SET_ADDR_CS.
- setValue  in  DW  register operand accompanying flagSetValue.
- flagExecProc  in  1  EXEC_PROGRAM issued this cycle (jump into user program).
- flagHALT  in  1  HLT issued this cycle.
- interruption  in  1  processor stalled (waiting for input); freezes counting.
- pcCurrent  in  AW  PC of the instruction in the current cycle.
- flagCS  out  1  context-switch request to the control unit.
- addrCS  out  AW  OS context-switch routine address (register value).
- pcProcess  out  AW  PC saved at the last preemption.
- quantumLeft  out  QW  remaining instruction cycles in the current slice.
- multiprogEn  out  1  multiprogramming enabled.
- csCount  out  8  number of context switches performed, wraps at 255->0.

Behaviour:
- Reset (reset=0, async): state IDLE; flagCS=0; addrCS=0; pcProcess=0; quantumLeft=0; multiprogEn=0; csCount=0; internal quantum register=0.
- Config writes, at clock edge when reset=1:
  - flagSetValue=1: quantum <= setValue[QW-1:0].
  - flagSetValue=2: multiprogEn <= setValue[0].
  - flagSetValue=3: addrCS <= setValue[AW-1:0].
  - Writes are accepted in every state. A write never alters quantumLeft of a running slice; a new quantum takes effect at the next reload.
- States: IDLE, RUN, SWITCH, WAIT_OS.
- IDLE:
  - flagExecProc=1 with multiprogEn=1 and quantum!=0: go to RUN, quantumLeft <= quantum.
  - Otherwise stay in IDLE; quantumLeft held at 0.
- RUN:
  - Each cycle with interruption=0, quantumLeft decrements by 1. With interruption=1 it holds.
  - flagHALT=1: go to IDLE, quantumLeft <= 0. This has priority over expiry in the same cycle.
  - flagExecProc=1: reload quantumLeft <= quantum and stay in RUN.
  - quantumLeft=1 with interruption=0 and no HALT: quantumLeft <= 0, go to SWITCH. The instruction in that cycle completes normally.
- SWITCH (exactly one cycle):
  - flagCS=1, decoded from state (registered, glitch-free).
  - pcProcess <= pcCurrent. This is the next unexecuted user instruction; the PC has not yet advanced because the control unit holds flagPC=2 during CS.
  - csCount <= csCount+1.
  - Unconditionally go to WAIT_OS. interruption, flagHALT and flagExecProc are ignored in SWITCH.
- WAIT_OS:
  - OS routine runs with no counting.
  - flagExecProc=1: go to RUN with reload if multiprogEn=1 and quantum!=0; otherwise go to IDLE.
  - flagHALT=1: go to IDLE.
- flagCS is 1 only in SWITCH; it is never asserted in any other state.
- Latency: expiry decision to flagCS is 1 clock. flagExecProc to first decrement is 1 clock (the reload cycle does not decrement).
- quantum=1: RUN lasts exactly one cycle, then SWITCH.
- Reset asserted in any state, including SWITCH, returns all outputs to reset values immediately. No pcProcess or csCount update occurs.
- multiprogEn cleared during RUN: the current slice still expires normally. The cleared value is only checked at the next EXEC_PROGRAM.

Test Plan:
- Reset, then write quantum=3, multiprog=1, addrCS=0x1F0; EXEC_PROGRAM at pcCurrent=0x040 -> quantumLeft 3,2,1,0 over the following cycles; flagCS=1 for exactly one cycle, 4 cycles after the EXEC cycle; pcProcess=0x043; csCount=1; addrCS=0x1F0.
- Same setup with interruption=1 for 5 cycles mid-slice -> quantumLeft frozen during the stall; flagCS delayed by exactly 5 cycles.
- quantum=2 with HLT issued in the cycle where quantumLeft=1 -> state IDLE, flagCS never asserts, csCount unchanged.
- multiprog=0, EXEC_PROGRAM -> remains IDLE, quantumLeft=0, no flagCS for 100 cycles. Then write quantum=0 with multiprog=1 and EXEC -> still no preemption.
- After a switch, SET_QUANTUM=5 while in WAIT_OS, then EXEC_PROGRAM -> reload to 5, second flagCS after 5 run cycles, csCount=2. 256 forced switches -> csCount wraps to 0.
- Drive reset low in the SWITCH cycle -> flagCS drops asynchronously, pcProcess=0, csCount=0, state IDLE after reset is released.

Source files
------------

// File: rtl/quantum_scheduler_if.sv
// Control-unit <-> quantum scheduler signal bundle.
// master: control-unit side (drives config, exec/halt, stall, PC).
// slave : scheduler side (drives the context-switch request and status).
interface quantum_scheduler_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32,
    parameter int unsigned QW = 16
);
    logic [1:0]    flagSetValue;
    logic [DW-1:0] setValue;
    logic          flagExecProc;
    logic          flagHALT;
    logic          interruption;
    logic [AW-1:0] pcCurrent;
    logic          flagCS;
    logic [AW-1:0] addrCS;
    logic [AW-1:0] pcProcess;
    logic [QW-1:0] quantumLeft;
    logic          multiprogEn;
    logic [7:0]    csCount;

    modport master (
        output flagSetValue, setValue, flagExecProc, flagHALT, interruption, pcCurrent,
        input  flagCS, addrCS, pcProcess, quantumLeft, multiprogEn, csCount
    );

    modport slave (
        input  flagSetValue, setValue, flagExecProc, flagHALT, interruption, pcCurrent,
        output flagCS, addrCS, pcProcess, quantumLeft, multiprogEn, csCount
    );
endinterface

// File: rtl/quantum_scheduler.sv
// Preemption timer and context-switch sequencer.
// Counts user-program instruction cycles against a programmable quantum and,
// on expiry, spends one SWITCH cycle requesting a context switch while it
// captures the preempted PC; it then idles in WAIT_OS until the OS resumes.
module quantum_scheduler #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32,
    parameter int unsigned QW = 16
) (
    input  logic               clock,
    input  logic               reset,
    quantum_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SWITCH  = 2'd2,
        WAIT_OS = 2'd3
    } state_t;

    localparam logic [QW-1:0] QONE = QW'(1);

    state_t        state_q, state_d;
    logic [QW-1:0] quantum_q, quantum_d;
    logic [QW-1:0] qleft_q, qleft_d;
    logic          mp_q, mp_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pcp_q, pcp_d;
    logic [7:0]    cs_q, cs_d;
    logic          can_start;

    // Only the low bits of the register operand are meaningful for any write.
    logic unused_setvalue;
    assign unused_setvalue = ^bus.setValue;

    // A slice can only be started when multiprogramming is on and the quantum is nonzero.
    assign can_start = mp_q && (quantum_q != '0);

    // Configuration writes, accepted in every state.
    always_comb begin
        quantum_d = quantum_q;
        mp_d      = mp_q;
        addr_d    = addr_q;
        case (bus.flagSetValue)
            2'd1:    quantum_d = bus.setValue[QW-1:0];
            2'd2:    mp_d      = bus.setValue[0];
            2'd3:    addr_d    = bus.setValue[AW-1:0];
            default: ;
        endcase
    end

    // Next-state and slice-counter logic.
    always_comb begin
        state_d = state_q;
        qleft_d = qleft_q;
        pcp_d   = pcp_q;
        cs_d    = cs_q;
        unique case (state_q)
            IDLE: begin
                qleft_d = '0;
                if (bus.flagExecProc && can_start) begin
                    state_d = RUN;
                    qleft_d = quantum_q;
                end
            end
            RUN: begin
                if (bus.flagHALT) begin
                    state_d = IDLE;
                    qleft_d = '0;
                end else if (bus.flagExecProc) begin
                    qleft_d = quantum_q;
                end else if (!bus.interruption) begin
                    // A slice reloaded with a zero quantum expires at once instead of wrapping.
                    if (qleft_q <= QONE) begin
                        state_d = SWITCH;
                        qleft_d = '0;
                    end else begin
                        qleft_d = qleft_q - QONE;
                    end
                end
            end
            SWITCH: begin
                // PC is held by the control unit here, so it is the next unexecuted instruction.
                pcp_d   = bus.pcCurrent;
                cs_d    = cs_q + 8'd1;
                qleft_d = '0;
                state_d = WAIT_OS;
            end
            WAIT_OS: begin
                qleft_d = '0;
                if (bus.flagHALT) begin
                    state_d = IDLE;
                end else if (bus.flagExecProc) begin
                    if (can_start) begin
                        state_d = RUN;
                        qleft_d = quantum_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                qleft_d = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            quantum_q <= '0;
            qleft_q   <= '0;
            mp_q      <= 1'b0;
            addr_q    <= '0;
            pcp_q     <= '0;
            cs_q      <= '0;
        end else begin
            state_q   <= state_d;
            quantum_q <= quantum_d;
            qleft_q   <= qleft_d;
            mp_q      <= mp_d;
            addr_q    <= addr_d;
            pcp_q     <= pcp_d;
            cs_q      <= cs_d;
        end
    end

    assign bus.flagCS      = (state_q == SWITCH);
    assign bus.addrCS      = addr_q;
    assign bus.pcProcess   = pcp_q;
    assign bus.quantumLeft = qleft_q;
    assign bus.multiprogEn = mp_q;
    assign bus.csCount     = cs_q;

endmodule
